rr_stream_mux: RTL

- Parametrised N-channel, W-bit stream multiplexer; successor to the combinational 4:1 mux.
- Adds valid/ready handshaking on every input and on the output, plus a registered output stage.
- Two selection modes: fixed select and fair round-robin arbitration.
- Sits between multiple producer blocks and a single consumer datapath.

---
 rtl/rr_stream_mux_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 63 ++++++
 rtl/rr_stream_mux.sv | 109 ++++++++++
 3 files changed

// File: rtl/rr_stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream mux.
// Mode encodings and a ceiling-log2 used to size channel ids.
package rr_stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Fair round-robin arbiter with its own rotating priority pointer.
// The pointer moves past the granted channel only when told to advance.
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] req_i,
    input  logic                advance_i,
    output logic [SEL_W-1:0]    grant_o,
    output logic                grant_valid_o
);

    logic [SEL_W-1:0]    ptr_q;
    logic [SEL_W-1:0]    ptr_d;
    logic [SEL_W:0]      idx;
    logic [CHANNELS-1:0] onehot;

    // Scan from ptr upward with wrap; walking backwards lets the
    // closest requester to ptr overwrite any farther one.
    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        idx           = '0;
        onehot        = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + (SEL_W + 1)'(k);
            if (int'(idx) >= CHANNELS) begin
                idx = idx - (SEL_W + 1)'(CHANNELS);
            end
            onehot = CHANNELS'(1) << idx;
            if (|(req_i & onehot)) begin
                grant_o       = idx[SEL_W-1:0];
                grant_valid_o = 1'b1;
            end
        end
    end

    // Next pointer is one past the winner, wrapping at the last channel.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && grant_valid_o) begin
            if (int'(grant_o) == CHANNELS - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_o + SEL_W'(1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with a registered output stage.
// Fixed-select or round-robin choice of the source channel.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] chan_q, chan_d;
    logic             valid_q, valid_d;

    logic             load;
    logic             fix_valid;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_valid;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             xfer;
    logic [WIDTH-1:0] word;

    rr_arbiter #(
        .CHANNELS(CHANNELS)
    ) u_arb (
        .clk          (clk),
        .rst          (rst),
        .req_i        (in_valid),
        .advance_i    (xfer && (mode == MODE_RR)),
        .grant_o      (rr_grant),
        .grant_valid_o(rr_valid)
    );

    // Mode mux; an out-of-range sel shifts the mask to zero, so no grant.
    always_comb begin
        load        = !valid_q || out_ready;
        fix_valid   = |(in_valid & (CHANNELS'(1) << sel));
        grant       = sel;
        grant_valid = fix_valid;
        if (mode == MODE_RR) begin
            grant       = rr_grant;
            grant_valid = rr_valid;
        end
        xfer = load && grant_valid;
    end

    // One-hot accept, forced low while reset is held.
    always_comb begin
        in_ready = '0;
        if (xfer && !rst) begin
            in_ready = CHANNELS'(1) << grant;
        end
    end

    // Pick the granted channel's word out of the packed bus.
    always_comb begin
        word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                word = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage: load on transfer, drain when idle, hold under stall.
    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        if (xfer) begin
            data_d  = word;
            chan_d  = grant;
            valid_d = 1'b1;
        end else if (load) begin
            valid_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

endmodule
